video_wr_packer: RTL and testbench

VIDEO_WR_PACKER -- requirements
Module: video_wr_packer

---
 rtl/video_wr_packer.sv | 167 ++++++++++++++++
 tb/tb_video_wr_packer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_wr_packer.sv
// Packs 32-bit scaled pixels into 256-bit words, buffers them in a show-ahead FIFO
// and issues write bursts into one of two ping-pong frame buffers.
module video_wr_packer #(
    parameter int          BURST_LEN   = 8,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [27:0] FRAME_BASE0 = 28'h0000000,
    parameter logic [27:0] FRAME_BASE1 = 28'h0100000
) (
    input  logic         pixclk_in,
    input  logic         rst_n,
    input  logic         vs_in,
    input  logic         de_in,
    input  logic [31:0]  wr_data,
    output logic         mem_wr_req,
    output logic [27:0]  mem_wr_addr,
    output logic [4:0]   mem_wr_len,
    input  logic         mem_wr_ack,
    input  logic         mem_wr_en,
    output logic [255:0] mem_wr_data,
    output logic         frame_sel,
    output logic         frame_done,
    output logic         overflow
);
    // state | meaning
    // IDLE  | wait for a full burst, a flush, or a frame swap
    // REQ   | mem_wr_req high, addr/len held until mem_wr_ack
    // DATA  | count mem_wr_en strobes down to zero
    // SWAP  | toggle buffer, reload base address, pulse frame_done
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] BL_LVL   = LW'(BURST_LEN);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DATA, SWAP} state_t;
    state_t state;

    logic           vs_d;
    logic           vs_rise;
    logic [2:0]     k;
    logic [255:0]   word;
    logic [255:0]   word_nxt;
    logic [255:0]   push_word;
    logic           push_v;
    logic [255:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic           push_ok;
    logic           pop;
    logic           frame_pend;
    logic [4:0]     cnt;

    assign vs_rise = vs_in & ~vs_d;
    assign push_ok = push_v && (level != FULL_LVL);
    assign pop     = (state == DATA) && mem_wr_en && (level != '0);
    assign mem_wr_data = (level != '0) ? mem[rd_ptr] : '0;

    always_comb begin
        word_nxt = word;
        if (de_in) word_nxt[{k, 5'b0} +: 32] = wr_data;
    end

    // Completed (or zero-padded partial) words are staged one cycle before the FIFO.
    always_ff @(posedge pixclk_in or negedge rst_n) begin
        if (!rst_n) begin
            vs_d      <= 1'b0;
            k         <= '0;
            word      <= '0;
            push_word <= '0;
            push_v    <= 1'b0;
        end else begin
            vs_d   <= vs_in;
            push_v <= 1'b0;
            if ((de_in && k == 3'd7) || (vs_rise && k != 3'd0)) begin
                push_word <= word_nxt;
                push_v    <= 1'b1;
                word      <= '0;
                k         <= '0;
            end else if (de_in) begin
                word <= word_nxt;
                k    <= k + 3'd1;
            end
        end
    end

    always_ff @(posedge pixclk_in) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge pixclk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push_v && level == FULL_LVL) overflow <= 1'b1;
            else if (vs_rise)                overflow <= 1'b0;
        end
    end

    always_ff @(posedge pixclk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= FRAME_BASE0;
            mem_wr_len  <= '0;
            cnt         <= '0;
            frame_sel   <= 1'b0;
            frame_done  <= 1'b0;
            frame_pend  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (level >= BL_LVL) begin
                        mem_wr_len <= 5'(BURST_LEN);
                        mem_wr_req <= 1'b1;
                        state      <= REQ;
                    end else if (frame_pend && !push_v) begin
                        if (level != '0) begin
                            mem_wr_len <= 5'(level);
                            mem_wr_req <= 1'b1;
                            state      <= REQ;
                        end else begin
                            state <= SWAP;
                        end
                    end
                end
                REQ: begin
                    if (mem_wr_ack) begin
                        mem_wr_req <= 1'b0;
                        cnt        <= mem_wr_len;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (pop) begin
                        if (cnt == 5'd1) begin
                            mem_wr_addr <= mem_wr_addr + 28'({mem_wr_len, 5'b0});
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                end
                SWAP: begin
                    frame_sel   <= ~frame_sel;
                    mem_wr_addr <= frame_sel ? FRAME_BASE0 : FRAME_BASE1;
                    frame_pend  <= 1'b0;
                    frame_done  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A new frame edge outranks the clear in SWAP so it is never lost.
            if (vs_rise) frame_pend <= 1'b1;
        end
    end
endmodule

// File: tb/tb_video_wr_packer.sv
// Directed bench for video_wr_packer: scoreboard of expected 256-bit words
// built from the driven pixels, checked as the bench strobes mem_wr_en.
module tb_video_wr_packer;
    logic         pixclk_in = 1'b0;
    logic         rst_n = 1'b0;
    logic         vs_in = 1'b0;
    logic         de_in = 1'b0;
    logic [31:0]  wr_data = '0;
    logic         mem_wr_req;
    logic [27:0]  mem_wr_addr;
    logic [4:0]   mem_wr_len;
    logic         mem_wr_ack = 1'b0;
    logic         mem_wr_en = 1'b0;
    logic [255:0] mem_wr_data;
    logic         frame_sel;
    logic         frame_done;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    logic [255:0] exp_q[$];
    logic [255:0] t_word = '0;
    int           t_k = 0;
    logic         exp_ovf = 1'b0;

    video_wr_packer dut (
        .pixclk_in  (pixclk_in),
        .rst_n      (rst_n),
        .vs_in      (vs_in),
        .de_in      (de_in),
        .wr_data    (wr_data),
        .mem_wr_req (mem_wr_req),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_len (mem_wr_len),
        .mem_wr_ack (mem_wr_ack),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .frame_sel  (frame_sel),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 pixclk_in = ~pixclk_in;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [255:0] w);
        if (exp_q.size() >= 16) exp_ovf = 1'b1;
        else exp_q.push_back(w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pixclk_in);
            de_in = 1'b0;
        end
    endtask

    task automatic pixel(input logic [31:0] d);
        @(negedge pixclk_in);
        de_in = 1'b1;
        wr_data = d;
        t_word[32*t_k +: 32] = d;
        if (t_k == 7) begin
            push_exp(t_word);
            t_word = '0;
            t_k = 0;
        end else begin
            t_k++;
        end
    endtask

    task automatic pixels(input int n, input int first);
        for (int i = 0; i < n; i++) pixel(32'(first + i));
    endtask

    task automatic vs_pulse();
        @(negedge pixclk_in);
        de_in = 1'b0;
        vs_in = 1'b1;
        if (t_k != 0) begin
            push_exp(t_word);
            t_word = '0;
            t_k = 0;
        end
        @(negedge pixclk_in);
        vs_in = 1'b0;
    endtask

    task automatic serve(input logic [27:0] ea, input int el, input int vs_at, input int abort_at);
        int n = 0;
        logic [255:0] e;
        @(negedge pixclk_in);
        de_in = 1'b0;
        while (!mem_wr_req && n < 300) begin
            @(negedge pixclk_in);
            n++;
        end
        chk("req_seen", 256'(mem_wr_req), 256'(1));
        if (!mem_wr_req) return;
        chk("req_addr", 256'(mem_wr_addr), 256'(ea));
        chk("req_len", 256'(mem_wr_len), 256'(el));
        mem_wr_ack = 1'b1;
        @(negedge pixclk_in);
        mem_wr_ack = 1'b0;
        chk("req_drop", 256'(mem_wr_req), 256'(0));
        for (int i = 0; i < el; i++) begin
            if (i == abort_at) begin
                mem_wr_en = 1'b0;
                vs_in = 1'b0;
                return;
            end
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 256'hx;
            chk("burst_data", mem_wr_data, e);
            mem_wr_en = 1'b1;
            vs_in = (i == vs_at);
            @(negedge pixclk_in);
        end
        mem_wr_en = 1'b0;
        vs_in = 1'b0;
    endtask

    task automatic wait_done(input logic exp_sel, input logic [27:0] exp_addr);
        int n = 0;
        while (!frame_done && n < 100) begin
            @(negedge pixclk_in);
            chk("no_req_before_swap", 256'(mem_wr_req), 256'(0));
            n++;
        end
        chk("frame_done_seen", 256'(frame_done), 256'(1));
        chk("frame_sel", 256'(frame_sel), 256'(exp_sel));
        chk("swap_addr", 256'(mem_wr_addr), 256'(exp_addr));
        @(negedge pixclk_in);
        chk("frame_done_pulse", 256'(frame_done), 256'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 256'(mem_wr_req), 256'(0));
        chk({tag, "_addr"}, 256'(mem_wr_addr), 256'(28'h0000000));
        chk({tag, "_len"}, 256'(mem_wr_len), 256'(0));
        chk({tag, "_data"}, mem_wr_data, 256'(0));
        chk({tag, "_sel"}, 256'(frame_sel), 256'(0));
        chk({tag, "_done"}, 256'(frame_done), 256'(0));
        chk({tag, "_ovf"}, 256'(overflow), 256'(0));
    endtask

    initial begin
        // reset
        idle(3);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        idle(2);

        // 64 pixels: no request until the 8th word lands
        pixels(56, 1);
        idle(5);
        chk("no_req_7_words", 256'(mem_wr_req), 256'(0));
        pixels(8, 57);
        idle(4);
        chk("req_after_8_words", 256'(mem_wr_req), 256'(1));
        chk("word0_lsb_pixel", 256'(mem_wr_data[31:0]), 256'(32'h1));
        chk("word0_msb_pixel", 256'(mem_wr_data[255:224]), 256'(32'h8));
        serve(28'h0000000, 8, -1, -1);

        // second burst advances by 256 bytes
        pixels(64, 65);
        serve(28'h0000100, 8, -1, -1);

        // 20 pixels then vs: flush 3 words incl. zero-padded partial, then swap
        pixels(20, 1);
        vs_pulse();
        serve(28'h0000200, 3, -1, -1);
        wait_done(1'b1, 28'h0100000);

        // overflow: ack withheld, 17 words pushed, 17th dropped
        pixels(136, 1000);
        idle(5);
        chk("overflow_set", 256'(overflow), 256'(exp_ovf));
        chk("fifo_held_16", 256'(exp_q.size()), 256'(16));
        idle(3);
        chk("overflow_sticky", 256'(overflow), 256'(1));
        vs_pulse();
        chk("overflow_cleared", 256'(overflow), 256'(0));
        exp_ovf = 1'b0;
        serve(28'h0100000, 8, -1, -1);
        serve(28'h0100100, 8, -1, -1);
        wait_done(1'b0, 28'h0000000);

        // vs during DATA: burst completes, then swap
        pixels(64, 2000);
        serve(28'h0000000, 8, 3, -1);
        wait_done(1'b1, 28'h0100000);

        // reset after 3 of 8 strobes
        pixels(64, 3000);
        serve(28'h0100000, 8, -1, 3);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midburst_rst");
        exp_q.delete();
        @(negedge pixclk_in);
        rst_n = 1'b1;
        mem_wr_en = 1'b1;
        idle(4);
        mem_wr_en = 1'b0;
        chk("post_rst_empty", mem_wr_data, 256'(0));
        chk("post_rst_no_req", 256'(mem_wr_req), 256'(0));
        pixels(64, 4000);
        serve(28'h0000000, 8, -1, -1);
        idle(2);
        chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
